// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the slave receive path and the transmit controller.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_DATA     = 3'd3,
        ST_DATA_ACK = 3'd4,
        ST_IGNORE   = 3'd5
    } i2c_rx_state_t;

    localparam logic [6:0] I2C_DEFAULT_SLAVE_ADDR = 7'h50;
    localparam logic       I2C_ACK                = 1'b0;
    localparam logic       I2C_NACK               = 1'b1;
    localparam int         I2C_DATA_W             = 8;

endpackage

// File: rtl/i2c_slave_rx_if.sv
// Valid/ready byte stream from the I2C slave receiver to its local consumer.
interface i2c_slave_rx_if;
    import i2c_pkg::*;

    logic [I2C_DATA_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises raw SCL/SDA and produces registered START/STOP and SCL edge strobes.
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic start_stb,
    output logic stop_stb,
    output logic scl_rise,
    output logic scl_fall
);
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;
    logic       scl_prev_reg;
    logic       sda_prev_reg;
    logic       start_reg;
    logic       stop_reg;
    logic       rise_reg;
    logic       fall_reg;

    // Line history resets to the idle-bus level so release of reset creates no false edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
            rise_reg     <= 1'b0;
            fall_reg     <= 1'b0;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], scl_in};
            sda_sync_reg <= {sda_sync_reg[0], sda_in};
            scl_prev_reg <= scl_sync_reg[1];
            sda_prev_reg <= sda_sync_reg[1];
            rise_reg     <= scl_sync_reg[1] & ~scl_prev_reg;
            fall_reg     <= ~scl_sync_reg[1] & scl_prev_reg;
            start_reg    <= scl_sync_reg[1] & scl_prev_reg & ~sda_sync_reg[1] & sda_prev_reg;
            stop_reg     <= scl_sync_reg[1] & scl_prev_reg & sda_sync_reg[1] & ~sda_prev_reg;
        end
    end

    // sda_prev_reg holds the SDA level that the current strobes were computed from.
    assign sda       = sda_prev_reg;
    assign start_stb = start_reg;
    assign stop_stb  = stop_reg;
    assign scl_rise  = rise_reg;
    assign scl_fall  = fall_reg;
endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only slave: address match, ACK generation and a two-slot ping-pong receive buffer.
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_SLAVE_ADDR,
    parameter int         MAX_BYTES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    i2c_slave_rx_if.master        rx,
    output logic                  addr_match,
    output logic                  overrun,
    output logic                  stop_seen,
    output logic [5:0]            byte_cnt,
    output logic                  busy
);
    logic sda, start_stb, stop_stb, scl_rise, scl_fall;

    i2c_line_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda       (sda),
        .start_stb (start_stb),
        .stop_stb  (stop_stb),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall)
    );

    i2c_rx_state_t state_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shift_reg;
    logic [5:0]    byte_cnt_reg;
    logic          ack_phase_reg, sda_oe_reg, addr_match_reg, overrun_reg, stop_seen_reg;
    logic          wp_reg, rp_reg;
    logic [1:0]    full_vec;
    logic [7:0]    slot_data [2];

    logic [7:0] shift_next;
    logic       byte_done, cap_ok, slot_free, wr_en, pop;

    assign shift_next = {shift_reg[6:0], sda};
    assign byte_done  = (state_reg == ST_DATA) && scl_rise && (bit_cnt_reg == 3'd7);
    assign cap_ok     = 32'(byte_cnt_reg) < 32'(MAX_BYTES);
    assign pop        = full_vec[rp_reg] & rx.rx_ready;
    // A slot being popped this cycle can be rewritten in the same cycle.
    assign slot_free  = ~full_vec[wp_reg] | (pop & (rp_reg == wp_reg));
    assign wr_en      = byte_done & cap_ok & slot_free;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
        logic [7:0] data_reg;
        logic       full_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                data_reg <= 8'h00;
                full_reg <= 1'b0;
            end else if (wr_en && (wp_reg == 1'(gi))) begin
                data_reg <= shift_next;
                full_reg <= 1'b1;
            end else if (pop && (rp_reg == 1'(gi))) begin
                full_reg <= 1'b0;
            end
        end

        assign slot_data[gi] = data_reg;
        assign full_vec[gi]  = full_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_reg <= 1'b0;
            rp_reg <= 1'b0;
        end else begin
            if (wr_en) wp_reg <= ~wp_reg;
            if (pop)   rp_reg <= ~rp_reg;
        end
    end

    always_ff @(posedge clk) begin
        stop_seen_reg <= 1'b0;
        if (rst) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 3'd0;
            shift_reg      <= 8'h00;
            byte_cnt_reg   <= 6'd0;
            ack_phase_reg  <= 1'b0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (start_stb) begin
            state_reg      <= ST_ADDR;
            bit_cnt_reg    <= 3'd0;
            byte_cnt_reg   <= 6'd0;
            ack_phase_reg  <= 1'b0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (stop_stb) begin
            state_reg      <= ST_IDLE;
            bit_cnt_reg    <= 3'd0;
            ack_phase_reg  <= 1'b0;
            sda_oe_reg     <= 1'b0;
            addr_match_reg <= 1'b0;
            stop_seen_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_ADDR: if (scl_rise) begin
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7)
                        state_reg <= (shift_next[7:1] == SLAVE_ADDR && !shift_next[0])
                                     ? ST_ADDR_ACK : ST_IGNORE;
                end
                // ACK is held from the fall ending bit 8 to the fall ending the ninth clock.
                ST_ADDR_ACK, ST_DATA_ACK: if (scl_fall) begin
                    if (!ack_phase_reg) begin
                        sda_oe_reg    <= 1'b1;
                        ack_phase_reg <= 1'b1;
                        if (state_reg == ST_ADDR_ACK) addr_match_reg <= 1'b1;
                    end else begin
                        sda_oe_reg    <= 1'b0;
                        ack_phase_reg <= 1'b0;
                        state_reg     <= ST_DATA;
                    end
                end
                ST_DATA: if (scl_rise) begin
                    shift_reg   <= shift_next;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        if (wr_en) begin
                            state_reg <= ST_DATA_ACK;
                            if (byte_cnt_reg != 6'd63) byte_cnt_reg <= byte_cnt_reg + 6'd1;
                        end else begin
                            state_reg <= ST_IGNORE;
                            if (cap_ok) overrun_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx.rx_valid = full_vec[rp_reg];
    assign rx.rx_data  = slot_data[rp_reg];
    assign sda_oe      = sda_oe_reg;
    assign addr_match  = addr_match_reg;
    assign overrun     = overrun_reg;
    assign stop_seen   = stop_seen_reg;
    assign byte_cnt    = byte_cnt_reg;
    assign busy        = (state_reg != ST_IDLE);
endmodule

// File: doc/i2c_slave_rx.md
# i2c_slave_rx

Receiving end of the double-buffered I2C write path: an I2C slave that detects START/STOP, matches its 7-bit address, ACKs write transfers and deserialises data bytes into a two-slot ping-pong buffer. A local consumer drains the buffer through a valid/ready handshake. It sits opposite the transmit controller on the same SDA/SCL pair. SCL and SDA are oversampled by `clk`.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this slave answers.
- `MAX_BYTES`, default 16: data bytes ACKed per transaction; later bytes are NACKed.
- `clk  in  1`: system clock, at least 8x SCL frequency.
- `rst  in  1`: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- `scl_in  in  1`: raw SCL.
- `sda_in  in  1`: raw SDA.
- `sda_oe  out  1`: 1 = pull SDA low (ACK); external open-drain.
- `rx_data  out  8`: byte at the read slot.
- `rx_valid  out  1`: read slot holds a byte.
- `rx_ready  in  1`: consumer accepts `rx_data` when `rx_valid`.
- `addr_match  out  1`: high from the address ACK until STOP or the next START.
- `overrun  out  1`: sticky. Set when a byte arrives with both slots full. Cleared on the next START.
- `stop_seen  out  1`: one-cycle pulse on STOP detection.
- `byte_cnt  out  6`: bytes ACKed in the current transaction. Saturates at 63.
- `busy  out  1`: state is not IDLE.

## Operation
- Line conditioning: 2-flop synchroniser on each of SCL and SDA, plus one registered previous value of each.
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
  - Rise and fall strobes are generated for SCL.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB-first, sampled on SCL rise.
  - ADDR_ACK: entered after the 8th sample.
    - If addr[7:1]==SLAVE_ADDR and R/W==0: assert `sda_oe` from the next SCL fall to the following SCL fall, set `addr_match`, go to DATA.
    - Otherwise: leave `sda_oe` at 0 and go to IGNORE.
  - DATA: shift 8 bits, then go to DATA_ACK.
  - DATA_ACK: write the byte and ACK, or NACK and go to IGNORE.
  - IGNORE: `sda_oe`=0 until STOP or START.
- Any START, in any state including a repeated START: go to ADDR, clear the bit counter, `byte_cnt` and `overrun`. Buffer contents are kept.
- Any STOP: go to IDLE, pulse `stop_seen`, clear `addr_match`. A partial byte is discarded.
- Ping-pong buffer: slots 0/1, each with a full flag; write pointer `wp`, read pointer `rp`.
  - `rx_valid`=full[rp]; `rx_data`=slot[rp].
  - Pop on `rx_valid & rx_ready`: clear full[rp], toggle `rp`.
- Byte completion in DATA (8th sample):
  - If `byte_cnt`==MAX_BYTES: NACK, drop the byte, go to IGNORE.
  - Else if full[wp] is set and not freed by a pop in the same cycle: NACK, drop the byte, set `overrun`, go to IGNORE.
  - Else: write slot[wp], set full[wp], toggle `wp`, increment `byte_cnt`, ACK.
- Pop and write in the same cycle are both honoured.
- Reset values: all outputs 0, both slots empty, `wp`=`rp`=0, state IDLE.
- Reset mid-transfer: the block aborts silently and does not drive SDA until a new START.

## Timing
- Edge detect latency: 3 `clk` from a raw pin edge to the internal strobe (2 sync + 1 edge register).
- Byte write: full flag set and `rx_valid` high 1 cycle after the 8th SCL-rise strobe.
- `sda_oe` timing:
  - Asserts 1 cycle after the SCL-fall strobe that ends bit 8.
  - Deasserts 1 cycle after the next SCL-fall strobe.
- `stop_seen`: asserted 1 cycle after the STOP strobe, for exactly 1 cycle.
- A pop is accepted in the same cycle `rx_valid & rx_ready` is seen; the slot is free on the next cycle.
- Throughput: the consumer must pop within one byte time (about 9 SCL periods) to avoid overrun with both slots filling.

## Structure
- Package `i2c_pkg`:
  - State enum `i2c_rx_state_t`.
  - Default `SLAVE_ADDR`.
  - `I2C_ACK`/`I2C_NACK` constants, shared with the transmit side.
- Sub-module `i2c_line_sync`: synchronisers plus START/STOP/SCL-rise/SCL-fall strobes. The remaining state machine, shift register and ping-pong buffer live in `i2c_slave_rx`.

## Test plan
- START, 0xA0, 0x3C, 0x5A, STOP with `rx_ready`=1:
  - Both address and data ACKs are driven.
  - `rx_data` shows 0x3C then 0x5A.
  - `byte_cnt`=2.
  - `stop_seen` pulses once.
- START, 0xA2 (wrong address) -> no ACK, `addr_match`=0, no `rx_valid` through STOP.
- START, 0xA1 (read request) -> NACK, IGNORE until STOP.
- `rx_ready`=0 and 3 data bytes:
  - Bytes 1-2 are ACKed.
  - Byte 3 is NACKed and `overrun`=1.
  - A later START clears `overrun`; slots still hold bytes 1 and 2.
- MAX_BYTES=2, 3 data bytes sent -> the third is NACKed and `byte_cnt` stays 2.
- Repeated START mid-byte, then `rst` mid-DATA -> state returns to ADDR, then all outputs 0 with `sda_oe` never asserted afterwards.
